// File: rtl/clk_div_ctrl.sv
// Clock-divider ratio sequencer. Arbitrates two ratio requesters round-robin,
// gates the divider clock while the new ratio is loaded, then lets it settle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | divider running; requests arbitrated and accepted here
// ST_DRAIN  | clock gated, one cycle for the divider to go quiet
// ST_LOAD   | pending ratio copied onto o_div_ratio
// ST_SETTLE | clock still gated for SETTLE_CYCLES while the divider settles
module clk_div_ctrl #(
  parameter int unsigned RATIO_WIDTH   = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned RESET_RATIO   = 1
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_req0_valid,
  input  logic [RATIO_WIDTH-1:0] i_req0_ratio,
  output logic                   o_req0_ready,
  input  logic                   i_req1_valid,
  input  logic [RATIO_WIDTH-1:0] i_req1_ratio,
  output logic                   o_req1_ready,
  output logic [RATIO_WIDTH-1:0] o_div_ratio,
  output logic                   o_clk_en,
  output logic                   o_busy,
  output logic                   o_grant_id,
  output logic                   o_update_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [7:0]             SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [RATIO_WIDTH-1:0] RATIO_RST   = RATIO_WIDTH'(RESET_RATIO);

  state_t                 state_q, state_d;
  logic [RATIO_WIDTH-1:0] div_ratio_q, div_ratio_d;
  logic [RATIO_WIDTH-1:0] pending_q, pending_d;
  logic [7:0]             settle_cnt_q, settle_cnt_d;
  logic                   grant_id_q, grant_id_d;
  logic                   done_q, done_d;

  logic                   grant_sel;
  logic                   hs;
  logic                   same_ratio;
  logic                   settle_last;
  logic [RATIO_WIDTH-1:0] req_ratio;

  // Round-robin: on contention the requester that did not win last time wins.
  always_comb begin
    grant_sel = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant_sel = ~grant_id_q;
    end else if (i_req1_valid) begin
      grant_sel = 1'b1;
    end
    req_ratio   = grant_sel ? i_req1_ratio : i_req0_ratio;
    hs          = (state_q == ST_IDLE) && !i_rst && (i_req0_valid || i_req1_valid);
    same_ratio  = (req_ratio == div_ratio_q);
    settle_last = (settle_cnt_q <= 8'd1);
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (hs && !same_ratio) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_SETTLE;
      ST_SETTLE: if (settle_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req0_ready = hs && !grant_sel;
    o_req1_ready = hs && grant_sel;
    o_clk_en     = (state_q == ST_IDLE) && i_enable;
    o_busy       = (state_q != ST_IDLE);
  end

  always_comb begin
    pending_d    = hs ? req_ratio : pending_q;
    grant_id_d   = hs ? grant_sel : grant_id_q;
    div_ratio_d  = (state_q == ST_LOAD) ? pending_q : div_ratio_q;
    settle_cnt_d = settle_cnt_q;
    if (state_q == ST_LOAD) begin
      settle_cnt_d = SETTLE_INIT;
    end else if (state_q == ST_SETTLE) begin
      settle_cnt_d = settle_cnt_q - 8'd1;
    end
    // A same-ratio request completes immediately, without leaving IDLE.
    done_d = (hs && same_ratio) || ((state_q == ST_SETTLE) && settle_last);
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      div_ratio_q  <= RATIO_RST;
      pending_q    <= '0;
      settle_cnt_q <= 8'd0;
      grant_id_q   <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      div_ratio_q  <= div_ratio_d;
      pending_q    <= pending_d;
      settle_cnt_q <= settle_cnt_d;
      grant_id_q   <= grant_id_d;
      done_q       <= done_d;
    end
  end

  assign o_div_ratio   = div_ratio_q;
  assign o_grant_id    = grant_id_q;
  assign o_update_done = done_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: table of single requests checked through a
// scoreboard, plus hand sequences for contention and mid-change reset.
module tb_clk_div_ctrl;

  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       rst, en, v0, v1;
  logic [7:0] r0, r1;
  logic       o_req0_ready, o_req1_ready, o_clk_en, o_busy, o_grant_id, o_update_done;
  logic [7:0] o_div_ratio;

  always #5 clk = ~clk;

  clk_div_ctrl #(
    .RATIO_WIDTH  (8),
    .SETTLE_CYCLES(SETTLE),
    .RESET_RATIO  (1)
  ) dut (
    .i_ref_clk    (clk),
    .i_rst        (rst),
    .i_enable     (en),
    .i_req0_valid (v0),
    .i_req0_ratio (r0),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (v1),
    .i_req1_ratio (r1),
    .o_req1_ready (o_req1_ready),
    .o_div_ratio  (o_div_ratio),
    .o_clk_en     (o_clk_en),
    .o_busy       (o_busy),
    .o_grant_id   (o_grant_id),
    .o_update_done(o_update_done)
  );

  typedef struct {
    logic       en;
    logic       v0;
    logic [7:0] r0;
    logic       v1;
    logic [7:0] r1;
    logic       exp_grant;
    logic [7:0] exp_ratio;
  } vec_t;

  typedef struct {
    int ratio;
    int grant;
    int lat;
    int low;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_ratio = 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1; en = 1'b1;
    v0 = 1'b1; r0 = 8'd5; v1 = 1'b1; r1 = 8'd7;
    repeat (2) begin
      step();
      check("rst_ready0", o_req0_ready, 0);
      check("rst_ready1", o_req1_ready, 0);
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    step();
    check("rst_ratio",  o_div_ratio, 1);
    check("rst_clk_en", o_clk_en, 1);
    check("rst_busy",   o_busy, 0);
    check("rst_grant",  o_grant_id, 1);
    check("rst_ready0_idle", o_req0_ready, 0);
    check("rst_ready1_idle", o_req1_ready, 0);
    check("rst_done",   o_update_done, 0);
    cur_ratio = 1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bit   hs = 1'b0;
    bit   done = 1'b0;
    bit   chg;
    int   k = 0;
    int   lowc = 0;
    int   busyc = 0;
    int   old;
    step();
    en = v.en; v0 = v.v0; r0 = v.r0; v1 = v.v1; r1 = v.r1;
    #1;
    for (int c = 0; c < 30 && !hs; c++) begin
      if ((o_req0_ready && v.v0) || (o_req1_ready && v.v1)) hs = 1'b1;
      else step();
    end
    if (!hs) begin
      check("vec_hs_timeout", 0, 1);
      v0 = 1'b0; v1 = 1'b0;
      return;
    end
    check("vec_grant_sel", int'(o_req1_ready), int'(v.exp_grant));
    chg = (int'(v.exp_ratio) != cur_ratio);
    old = cur_ratio;
    cur_ratio = int'(v.exp_ratio);
    e.ratio = int'(v.exp_ratio);
    e.grant = int'(v.exp_grant);
    e.lat   = chg ? SETTLE + 3 : 1;
    e.low   = chg ? SETTLE + 2 : 0;
    sb.push_back(e);
    while (!done && k < 60) begin
      step();
      k++;
      if (k == 1) begin v0 = 1'b0; v1 = 1'b0; end
      if (o_update_done) done = 1'b1;
      else begin
        if (!o_clk_en) lowc++;
        if (o_busy) busyc++;
        if (chg && k == 2) check("ratio_in_load", o_div_ratio, old);
        if (chg && k == 3) check("ratio_in_settle", o_div_ratio, int'(v.exp_ratio));
      end
    end
    if (!done) begin
      check("vec_done_timeout", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("vec_sb_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("vec_ratio",   o_div_ratio, e.ratio);
    check("vec_grant",   o_grant_id, e.grant);
    check("vec_latency", k, e.lat);
    check("vec_clk_low", lowc, e.low);
    check("vec_busy",    busyc, e.low);
    check("vec_clk_en_at_done", o_clk_en, int'(v.en));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   nd, k, dones;
    bit   exp_g, hs;

    vecs[0] = '{1'b1, 1'b1, 8'd6,   1'b0, 8'd0,  1'b0, 8'd6};
    vecs[1] = '{1'b1, 1'b1, 8'd6,   1'b0, 8'd0,  1'b0, 8'd6};
    vecs[2] = '{1'b1, 1'b0, 8'd0,   1'b1, 8'd6,  1'b1, 8'd6};
    vecs[3] = '{1'b1, 1'b1, 8'd4,   1'b1, 8'd10, 1'b0, 8'd4};
    vecs[4] = '{1'b1, 1'b1, 8'd4,   1'b1, 8'd10, 1'b1, 8'd10};
    vecs[5] = '{1'b1, 1'b0, 8'd0,   1'b1, 8'd0,  1'b1, 8'd0};
    vecs[6] = '{1'b1, 1'b1, 8'd1,   1'b0, 8'd0,  1'b0, 8'd1};
    vecs[7] = '{1'b0, 1'b1, 8'd3,   1'b0, 8'd0,  1'b0, 8'd3};
    vecs[8] = '{1'b1, 1'b1, 8'd255, 1'b1, 8'd1,  1'b1, 8'd1};

    rst = 1'b1; en = 1'b0; v0 = 1'b0; v1 = 1'b0; r0 = '0; r1 = '0;
    do_reset();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both requesters held valid: grants alternate, each next handshake
    // coincides with the previous done pulse.
    step();
    en = 1'b1; v0 = 1'b1; r0 = 8'd4; v1 = 1'b1; r1 = 8'd10;
    #1;
    nd = 0;
    exp_g = 1'b1;
    for (int c = 0; c < 200 && nd < 4; c++) begin
      if (c > 0) step();
      if (o_update_done) begin
        if (sb.size() == 0) check("alt_sb_underflow", 0, 1);
        else begin
          e = sb.pop_front();
          check("alt_ratio", o_div_ratio, e.ratio);
          check("alt_grant_id", o_grant_id, e.grant);
        end
        check("alt_ready_on_done", int'(o_req0_ready | o_req1_ready), 1);
        nd++;
      end
      if (nd < 4 && (o_req0_ready || o_req1_ready)) begin
        exp_g = ~exp_g;
        check("alt_grant_sel", int'(o_req1_ready), int'(exp_g));
        e.ratio = exp_g ? 10 : 4;
        e.grant = int'(exp_g);
        e.lat = 0;
        e.low = 0;
        sb.push_back(e);
      end
    end
    v0 = 1'b0; v1 = 1'b0;
    if (nd < 4) check("alt_done_timeout", nd, 4);
    cur_ratio = 10;

    // Reset in SETTLE during a 1->8 change aborts it with no done pulse.
    do_reset();
    step();
    v0 = 1'b1; r0 = 8'd8;
    #1;
    hs = 1'b0;
    for (int c = 0; c < 30 && !hs; c++) begin
      if (o_req0_ready) hs = 1'b1;
      else step();
    end
    check("abort_hs", int'(hs), 1);
    k = 0;
    while (k < 4) begin
      step();
      k++;
      if (k == 1) v0 = 1'b0;
    end
    check("abort_busy_in_settle", o_busy, 1);
    check("abort_ratio_in_settle", o_div_ratio, 8);
    rst = 1'b1; v0 = 1'b1; r0 = 8'd9;
    step();
    check("abort_ready_in_rst", o_req0_ready, 0);
    check("abort_idle", o_busy, 0);
    rst = 1'b0; v0 = 1'b0;
    step();
    check("abort_ratio", o_div_ratio, 1);
    check("abort_grant", o_grant_id, 1);
    check("abort_clk_en", o_clk_en, 1);
    dones = 0;
    repeat (10) begin
      if (o_update_done) dones++;
      step();
    end
    check("abort_no_done", dones, 0);
    cur_ratio = 1;

    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
